axis_video_frame_gate: RTL and testbench
========================================

# axis_video_frame_gate

Frame-synchronising gate placed directly downstream of the video-input-to-AXI4-Stream bridge, on the same `aclk` domain. It consumes the bridge's 8-bit AXI4-Stream video (`tuser` = start of frame, `tlast` = end of line) and discards everything until the first start of frame. It then forwards whole frames checked against a programmed width and height, regenerating `tlast`, flagging malformed lines and frames, and resynchronising automatically. Downstream consumers (VDMA, processing cores) are guaranteed to see only frames that begin with `tuser` and lines no longer than `cfg_width`.

## Interface
- `DATA_WIDTH`, 8: pixel width, `tdata` width.
- `DIM_BITS`, 12: width of the dimension registers and counters.
- `aclk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: sampled on each SOF beat; 0 drops that frame.
- `cfg_width` in DIM_BITS: active pixels per line; shadowed at SOF.
- `cfg_height` in DIM_BITS: lines per frame; shadowed at SOF.
- `s_axis_video_tdata` in DATA_WIDTH: input pixel.
- `s_axis_video_tvalid` in 1: input valid.
- `s_axis_video_tready` out 1: input ready.
- `s_axis_video_tuser` in 1: input SOF.
- `s_axis_video_tlast` in 1: input EOL.
- `m_axis_video_tdata` out DATA_WIDTH: output pixel.
- `m_axis_video_tvalid` out 1: output valid.
- `m_axis_video_tready` in 1: output ready.
- `m_axis_video_tuser` out 1: output SOF.
- `m_axis_video_tlast` out 1: output EOL, generated internally.
- `locked` out 1: last frame completed cleanly.
- `err_line` out 1: one-cycle pulse on a short or long line.
- `err_frame` out 1: one-cycle pulse on a premature SOF.
- `frame_count` out 16: clean frames completed, wraps at 0xFFFF→0.

## Operation
- States: WAIT_SOF, PASS. Beats are accepted in both states; WAIT_SOF discards non-SOF beats.
- WAIT_SOF, SOF beat accepted: shadow `cfg_*` and `enable`. If `enable`=1, `cfg_width`≠0 and `cfg_height`≠0, forward the beat with `tuser`=1, set pix=0 and line=0 (advanced per the rules below), and go to PASS. Otherwise drop the beat and stay in WAIT_SOF.
- PASS, per accepted beat (W, H = shadowed values; pix and line index the beat):
  - `tuser`=1 on a beat that is not the first of a frame: pulse `err_frame`, clear `locked`, and restart as a fresh SOF (same rules as WAIT_SOF).
  - `tlast`=1 with pix<W-1 (short line): forward with `m_tlast`=1, pulse `err_line`, clear `locked`, go to WAIT_SOF.
  - pix=W-1 with `tlast`=0 (long line): forward with `m_tlast`=1 (forced), pulse `err_line`, clear `locked`, go to WAIT_SOF. Excess pixels are discarded.
  - Otherwise forward the beat; `m_tlast`=(pix==W-1). pix wraps to 0 and line increments at end of line. At pix=W-1 and line=H-1: `frame_count`+1, set `locked`, go to WAIT_SOF.
- W=1: every beat carries `tlast`; `tuser` and `tlast` on the same beat is legal.
- Counters are DIM_BITS wide and unsigned. Comparisons use the shadowed W-1 and H-1.

## Timing
- Output is a 2-entry skid buffer. Latency is 1 cycle from input accept to `m_tvalid`. Sustained throughput is 1 beat/clk.
- `s_tready` is registered: it is 1 when the skid buffer has at least one free entry and is independent of `s_tvalid`, `s_tuser` and `s_tdata`.
- `m_tdata`, `m_tuser` and `m_tlast` are stable while `m_tvalid`=1 and `m_tready`=0.
- Reset values: `s_tready`=0 during `rst`, 1 on the first cycle after release. `m_tvalid`, `m_tuser`, `m_tlast`, `m_tdata`, `locked`, `err_line`, `err_frame` and `frame_count` are all 0.
- Reset mid-frame: state returns to WAIT_SOF, the skid buffer empties (buffered beats are lost), and counters clear. No partial `m_tvalid` survives reset.
- Error pulses fire on the cycle after the offending beat is accepted, aligned with the forwarded beat entering the skid buffer.
- Back-pressure never corrupts the counters: they advance only on an input handshake.

## Structure
- Shared package `video_axis_pkg`: state enum (WAIT_SOF, PASS), the `DIM_BITS` default, and a struct for {tdata, tuser, tlast}.
- Sub-module `axis_skid_buf`: 2-entry register slice, parameterised on payload width, reused elsewhere in the video path.

## Test plan
- W=4, H=3, 2 clean frames at full rate, `m_tready`=1 → 24 beats out, `tuser` on beats 0 and 12, `tlast` every 4th beat, `frame_count`=2, `locked`=1.
- 5 junk beats, then SOF → junk absent at the output, first output beat has `tuser`=1, and it appears 1 cycle after acceptance.
- W=4, line 1 ends with `tlast` at pix 2 → that beat has `m_tlast`=1, `err_line` pulses once, remaining beats are dropped until the next SOF, and `locked`=0.
- W=4, 6-pixel line without `tlast` → `m_tlast` forced on pix 3, `err_line` pulses, pixels 4-5 are dropped.
- Random `m_tready` (50%), W=1, H=1 → each beat carries `tuser`=`tlast`=1, no data is lost or duplicated, and `frame_count` equals the SOF count.
- `rst` asserted mid-line with the skid buffer full → the next cycle shows `m_tvalid`=0, `frame_count`=0, and the next output beat is a fresh SOF.

Source files
------------

// File: rtl/video_axis_pkg.sv
// Shared types for the 8-bit AXI4-Stream video path: gate states, dimension
// defaults and the per-beat payload carried alongside pixel data.
package video_axis_pkg;

  localparam int DIM_BITS_DEFAULT   = 12;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    PASS     = 1'b1
  } gate_state_e;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] tdata;
    logic                          tuser;
    logic                          tlast;
  } video_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI4-Stream register slice. Ready is registered and reflects a
// free slot; the head register drives the output directly.
module axis_skid_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic             ready_r;
  logic             valid_r;
  logic             push_s;
  logic             pop_s;

  // Handshake decode and next occupancy
  always_comb begin
    push_s = s_valid & ready_r;
    pop_s  = valid_r & m_ready;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, occupancy and registered flow-control flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      count_r <= 2'd0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != 2'd2);
      valid_r <= (count_nxt_s != 2'd0);
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= s_data;
          end else begin
            tail_r <= s_data;
          end
        end
        2'b01: head_r <= tail_r;
        2'b11: begin
          // Simultaneous push/pop: the head only takes the new beat when it was the sole entry
          if (count_r == 2'd1) begin
            head_r <= s_data;
          end else begin
            head_r <= tail_r;
            tail_r <= s_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_ready = ready_r;
  assign m_valid = valid_r;
  assign m_data  = head_r;

endmodule

// File: rtl/axis_video_frame_gate.sv
// Frame-synchronising gate: drops input until a start of frame, then forwards
// frames checked against shadowed width/height, regenerating tlast.
module axis_video_frame_gate
  import video_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DIM_BITS   = DIM_BITS_DEFAULT
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIM_BITS-1:0]   cfg_width,
  input  logic [DIM_BITS-1:0]   cfg_height,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  locked,
  output logic                  err_line,
  output logic                  err_frame,
  output logic [15:0]           frame_count
);

  gate_state_e         state_r;
  logic [DIM_BITS-1:0] pix_r;
  logic [DIM_BITS-1:0] line_r;
  logic [DIM_BITS-1:0] w_last_r;
  logic [DIM_BITS-1:0] h_last_r;
  logic                locked_r;
  logic                err_line_r;
  logic                err_frame_r;
  logic [15:0]         frame_count_r;

  logic                hs_s;
  logic                sof_ok_s;
  logic                start_s;
  logic                restart_s;
  logic                fwd_s;
  logic [DIM_BITS-1:0] pix_e_s;
  logic [DIM_BITS-1:0] line_e_s;
  logic [DIM_BITS-1:0] wl_e_s;
  logic [DIM_BITS-1:0] hl_e_s;
  logic                eol_s;
  logic                bad_line_s;
  logic                frame_done_s;
  logic                out_tlast_s;

  // Per-beat decision; a SOF beat is evaluated as pix 0 / line 0 of the new geometry
  always_comb begin
    hs_s      = s_axis_video_tvalid & s_axis_video_tready;
    sof_ok_s  = enable && (cfg_width != {DIM_BITS{1'b0}}) && (cfg_height != {DIM_BITS{1'b0}});
    start_s   = s_axis_video_tuser & sof_ok_s;
    restart_s = (state_r == PASS) & s_axis_video_tuser;
    case (state_r)
      WAIT_SOF: fwd_s = start_s;
      PASS:     fwd_s = s_axis_video_tuser ? sof_ok_s : 1'b1;
      default:  fwd_s = 1'b0;
    endcase
    if (start_s) begin
      pix_e_s  = {DIM_BITS{1'b0}};
      line_e_s = {DIM_BITS{1'b0}};
      wl_e_s   = cfg_width - DIM_BITS'(1);
      hl_e_s   = cfg_height - DIM_BITS'(1);
    end else begin
      pix_e_s  = pix_r;
      line_e_s = line_r;
      wl_e_s   = w_last_r;
      hl_e_s   = h_last_r;
    end
    eol_s        = (pix_e_s == wl_e_s);
    bad_line_s   = s_axis_video_tlast ^ eol_s;
    frame_done_s = eol_s & s_axis_video_tlast & (line_e_s == hl_e_s);
    out_tlast_s  = s_axis_video_tlast | eol_s;
  end

  // Frame/line tracking FSM with registered status and error pulses
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_r       <= WAIT_SOF;
      pix_r         <= {DIM_BITS{1'b0}};
      line_r        <= {DIM_BITS{1'b0}};
      w_last_r      <= {DIM_BITS{1'b0}};
      h_last_r      <= {DIM_BITS{1'b0}};
      locked_r      <= 1'b0;
      err_line_r    <= 1'b0;
      err_frame_r   <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      err_line_r  <= 1'b0;
      err_frame_r <= 1'b0;
      if (hs_s) begin
        if (restart_s) begin
          err_frame_r <= 1'b1;
          locked_r    <= 1'b0;
        end else begin
        end
        if (fwd_s) begin
          w_last_r <= wl_e_s;
          h_last_r <= hl_e_s;
          if (bad_line_s) begin
            err_line_r <= 1'b1;
            locked_r   <= 1'b0;
            state_r    <= WAIT_SOF;
          end else if (frame_done_s) begin
            frame_count_r <= frame_count_r + 16'd1;
            locked_r      <= 1'b1;
            state_r       <= WAIT_SOF;
          end else if (eol_s) begin
            pix_r   <= {DIM_BITS{1'b0}};
            line_r  <= line_e_s + DIM_BITS'(1);
            state_r <= PASS;
          end else begin
            pix_r   <= pix_e_s + DIM_BITS'(1);
            line_r  <= line_e_s;
            state_r <= PASS;
          end
        end else begin
          state_r <= WAIT_SOF;
        end
      end else begin
      end
    end
  end

  axis_skid_buf #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_skid (
    .clk     (aclk),
    .rst     (rst),
    .s_data  ({s_axis_video_tdata, start_s, out_tlast_s}),
    .s_valid (s_axis_video_tvalid & fwd_s),
    .s_ready (s_axis_video_tready),
    .m_data  ({m_axis_video_tdata, m_axis_video_tuser, m_axis_video_tlast}),
    .m_valid (m_axis_video_tvalid),
    .m_ready (m_axis_video_tready)
  );

  assign locked      = locked_r;
  assign err_line    = err_line_r;
  assign err_frame   = err_frame_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_axis_video_frame_gate.sv
// Randomised bench for axis_video_frame_gate against a beat-level frame model
// with an output scoreboard.
module tb_axis_video_frame_gate;
  import video_axis_pkg::*;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] cfg_width = 12'd4;
  logic [11:0] cfg_height = 12'd3;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic        locked;
  logic        err_line;
  logic        err_frame;
  logic [15:0] frame_count;

  axis_video_frame_gate #(.DATA_WIDTH(8), .DIM_BITS(12)) dut (
    .aclk(aclk), .rst(rst), .enable(enable),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready), .s_axis_video_tuser(s_tuser),
    .s_axis_video_tlast(s_tlast),
    .m_axis_video_tdata(m_tdata), .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready), .m_axis_video_tuser(m_tuser),
    .m_axis_video_tlast(m_tlast),
    .locked(locked), .err_line(err_line), .err_frame(err_frame),
    .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  bit          rdy_rand = 1'b0;
  video_beat_t exp_q[$];

  // reference model state: plain integer frame geometry
  bit m_in_frame = 1'b0;
  int m_w, m_h, m_pix, m_line;
  int m_frames = 0;
  bit m_locked = 1'b0;
  bit exp_el, exp_ef;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_in_frame = 1'b0;
    m_frames   = 0;
    m_locked   = 1'b0;
  endtask

  // One accepted input beat as seen by the frame rules
  task automatic model_accept(input logic [7:0] d, input bit u, input bit l);
    video_beat_t b;
    bit start, eol;
    exp_el = 1'b0;
    exp_ef = 1'b0;
    start  = 1'b0;
    if (m_in_frame && u) begin
      exp_ef     = 1'b1;
      m_locked   = 1'b0;
      m_in_frame = 1'b0;
    end
    if (!m_in_frame && u && enable && cfg_width != 12'd0 && cfg_height != 12'd0) begin
      m_w = int'(cfg_width);
      m_h = int'(cfg_height);
      m_pix = 0;
      m_line = 0;
      m_in_frame = 1'b1;
      start = 1'b1;
    end
    if (m_in_frame) begin
      eol = (m_pix == m_w - 1);
      b.tdata = d;
      b.tuser = start;
      b.tlast = l | eol;
      exp_q.push_back(b);
      if (l != eol) begin
        exp_el     = 1'b1;
        m_locked   = 1'b0;
        m_in_frame = 1'b0;
      end else if (eol) begin
        m_pix = 0;
        m_line++;
        if (m_line == m_h) begin
          m_frames++;
          m_locked   = 1'b1;
          m_in_frame = 1'b0;
        end
      end else begin
        m_pix++;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [7:0] d, input bit u, input bit l);
    int guard = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && guard < 500) begin
      @(negedge aclk);
      guard++;
    end
    check_eq("s_tready_wait", 32'(s_tready), 32'd1);
    @(posedge aclk);
    model_accept(d, u, l);
    @(negedge aclk);
    s_tvalid = 1'b0;
    check_eq("err_line", 32'(err_line), 32'(exp_el));
    check_eq("err_frame", 32'(err_frame), 32'(exp_ef));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("frame_count", 32'(frame_count), 32'(m_frames & 32'hFFFF));
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  task automatic send_frame(input int w, input int h);
    for (int i = 0; i < w * h; i++) begin
      send(8'($urandom), i == 0, (i % w) == w - 1);
    end
  endtask

  task automatic send_frame_rand(input int w, input int h);
    bit u, l;
    for (int i = 0; i < w * h; i++) begin
      u = (i == 0) || ($urandom_range(0, 39) == 0);
      l = ((i % w) == w - 1) ^ ($urandom_range(0, 29) == 0);
      send(8'($urandom), u, l);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge aclk) begin
    #1;
    if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
  end

  // Output scoreboard plus hold-stability check under back-pressure
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_beat;
  video_beat_t got_b;
  always @(negedge aclk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(m_tvalid), 32'd1);
        check_eq("hold_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(prev_beat));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          got_b = '{tdata: m_tdata, tuser: m_tuser, tlast: m_tlast};
          check_eq("out_beat", 32'(got_b), 32'(exp_q.pop_front()));
        end
        n_out++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tuser, m_tlast};
    end
  end

  int fc0;

  initial begin
    // reset values
    repeat (3) @(negedge aclk);
    check_eq("rst_s_tready", 32'(s_tready), 32'd0);
    check_eq("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_m_tuser", 32'(m_tuser), 32'd0);
    check_eq("rst_m_tlast", 32'(m_tlast), 32'd0);
    check_eq("rst_m_tdata", 32'(m_tdata), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_errs", 32'({err_line, err_frame}), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0;
    @(negedge aclk);
    check_eq("post_rst_s_tready", 32'(s_tready), 32'd1);
    m_tready = 1'b1;

    // two clean 4x3 frames at full rate
    n_out = 0;
    send_frame(4, 3);
    send_frame(4, 3);
    drain();
    check_eq("clean_beats", 32'(n_out), 32'd24);
    check_eq("clean_frames", 32'(frame_count), 32'd2);
    check_eq("clean_locked", 32'(locked), 32'd1);

    // junk before SOF, then first output one cycle after acceptance
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    check_eq("junk_dropped", 32'(m_tvalid), 32'd0);
    send(8'hA5, 1'b1, 1'b0);
    check_eq("sof_latency_valid", 32'(m_tvalid), 32'd1);
    check_eq("sof_latency_tuser", 32'(m_tuser), 32'd1);
    check_eq("sof_latency_tdata", 32'(m_tdata), 32'hA5);
    for (int i = 1; i < 12; i++) send(8'($urandom), 1'b0, (i % 4) == 3);
    drain();

    // short line: line 1 ends at pix 2
    for (int i = 0; i < 12; i++) send(8'($urandom), i == 0, (i % 4) == 3 || i == 6);
    drain();
    check_eq("short_locked", 32'(locked), 32'd0);

    // long line: six pixels without tlast
    for (int i = 0; i < 6; i++) send(8'($urandom), i == 0, 1'b0);
    drain();
    check_eq("long_locked", 32'(locked), 32'd0);

    // premature SOF mid-frame, then the new frame completes
    for (int i = 0; i < 3; i++) send(8'($urandom), i == 0, 1'b0);
    send_frame(4, 3);
    drain();
    check_eq("resync_locked", 32'(locked), 32'd1);

    // disabled and zero-width SOFs are dropped
    enable = 1'b0;
    send_frame(4, 3);
    enable = 1'b1;
    cfg_width = 12'd0;
    send_frame(4, 3);
    cfg_width = 12'd4;
    drain();

    // W=1, H=1 under random back-pressure
    cfg_width = 12'd1;
    cfg_height = 12'd1;
    rdy_rand = 1'b1;
    fc0 = int'(frame_count);
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'b1, 1'b1);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    rdy_rand = 1'b0;
    m_tready = 1'b1;
    drain();
    check_eq("w1_frames", 32'(frame_count), 32'(fc0 + 20));

    // random geometry, random corruption, random back-pressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      cfg_width  = 12'($urandom_range(1, 5));
      cfg_height = 12'($urandom_range(1, 3));
      enable     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'b0, 1'b0);
      send_frame_rand(int'(cfg_width), int'(cfg_height));
    end
    enable = 1'b1;
    rdy_rand = 1'b0;
    m_tready = 1'b1;
    drain();

    // reset mid-line with the skid buffer full
    cfg_width = 12'd4;
    cfg_height = 12'd3;
    m_tready = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    check_eq("full_s_tready", 32'(s_tready), 32'd0);
    rst = 1'b1;
    @(negedge aclk);
    check_eq("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("midrst_frame_count", 32'(frame_count), 32'd0);
    model_reset();
    rst = 1'b0;
    m_tready = 1'b1;
    send_frame(4, 3);
    drain();
    check_eq("post_rst_frames", 32'(frame_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
